spi_periph: RTL and testbench

Byte-oriented SPI peripheral (target) for SPI mode 0 (CPOL=0, CPHA=0), MSB first. It oversamples an external controller's SCLK/CS/PICO in the `i_clk` domain and shifts received bits into `o_rx_byte`. Transmit data for POCI comes from a one-entry holding buffer loaded by the local logic. It sits between the pads and local register/command logic and is the responder end of the team's SPI controller.

---
 rtl/spi_periph.sv | 168 ++++++++++++++++
 tb/tb_spi_periph.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_periph.sv
// SPI mode-0 target (MSB first), oversampled in the i_clk domain, with a one-entry TX holding buffer.
// Define SPI_PERIPH_ERR_EN to add the o_frame_err / o_tx_underrun pulse outputs.
module spi_periph #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs,
    input  logic       i_pico,
    output logic       o_poci,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_busy
`ifdef SPI_PERIPH_ERR_EN
    ,
    output logic       o_frame_err,
    output logic       o_tx_underrun
`endif
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_pico_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_pico_d;
    logic                   r_sclk_rise;
    logic                   r_sclk_fall;
    logic                   r_cs_rise;
    logic                   r_cs_fall;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;
    logic [7:0] r_buf;
    logic       r_buf_full;

    logic       w_wr;
    logic       w_load;
    logic [7:0] w_load_byte;

    // Edge pulses are registered so every action lands SYNC_STAGES+2 cycles after the pin edge;
    // r_pico_d is aligned with them so the sampled data bit matches the detected SCLK rise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_pico_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            r_pico_d    <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_pico_sync <= {r_pico_sync[SYNC_STAGES-2:0], i_pico};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            r_pico_d    <= r_pico_sync[SYNC_STAGES-1];
            r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
            r_sclk_fall <= ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
            r_cs_rise   <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
            r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
        end
    end

    assign w_wr        = i_tx_valid & ~r_buf_full;
    assign w_load      = ((r_state == ST_IDLE) & r_cs_fall) |
                         ((r_state == ST_ACTIVE) & ~r_cs_rise & r_sclk_fall & (r_bit_cnt == 3'd0));
    assign w_load_byte = r_buf_full ? r_buf : IDLE_BYTE;

    // A write can only land while the buffer is empty, so it never collides with a load that drains it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf      <= 8'h00;
            r_buf_full <= 1'b0;
        end else if (w_wr) begin
            r_buf      <= i_tx_byte;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_sr    <= 7'd0;
            r_tx_sr    <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_cs_fall) begin
                        r_tx_sr   <= w_load_byte;
                        r_bit_cnt <= 3'd0;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // CS release outranks any SCLK edge seen in the same cycle.
                    if (r_cs_rise) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= 3'd0;
                        r_rx_sr   <= 7'd0;
                        r_tx_sr   <= 8'h00;
                    end else if (r_sclk_rise) begin
                        r_rx_sr   <= {r_rx_sr[5:0], r_pico_d};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_byte  <= {r_rx_sr, r_pico_d};
                            r_rx_valid <= 1'b1;
                        end
                    end else if (r_sclk_fall) begin
                        if (r_bit_cnt != 3'd0) begin
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end else begin
                            r_tx_sr <= w_load_byte;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_PERIPH_ERR_EN
    logic r_frame_err;
    logic r_tx_underrun;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_err   <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_frame_err   <= (r_state == ST_ACTIVE) & r_cs_rise & (r_bit_cnt != 3'd0);
            r_tx_underrun <= w_load & ~r_buf_full;
        end
    end

    assign o_frame_err   = r_frame_err;
    assign o_tx_underrun = r_tx_underrun;
`endif

    // The shift register is zero outside a frame, so its MSB doubles as the idle-low POCI level.
    assign o_poci     = r_tx_sr[7];
    assign o_tx_ready = ~r_buf_full;
    assign o_rx_byte  = r_rx_byte;
    assign o_rx_valid = r_rx_valid;
    assign o_busy     = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_periph.sv
// Directed bench for spi_periph: a byte-level controller/buffer model plus a per-cycle RX monitor.
module tb_spi_periph;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_sclk;
  logic       i_cs;
  logic       i_pico;
  logic       o_poci;
  logic [7:0] i_tx_byte;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic       o_busy;
`ifdef SPI_PERIPH_ERR_EN
  logic       o_frame_err;
  logic       o_tx_underrun;
`endif

  spi_periph #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE_BYTE)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_sclk     (i_sclk),
    .i_cs       (i_cs),
    .i_pico     (i_pico),
    .o_poci     (o_poci),
    .i_tx_byte  (i_tx_byte),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .o_rx_byte  (o_rx_byte),
    .o_rx_valid (o_rx_valid),
    .o_busy     (o_busy)
`ifdef SPI_PERIPH_ERR_EN
    ,
    .o_frame_err   (o_frame_err),
    .o_tx_underrun (o_tx_underrun)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rx;
  logic [7:0] mon_e;
  int         rx_cnt;
  int         exp_underrun, exp_ferr, seen_underrun, seen_ferr;
  bit         mon_en;
  logic [7:0] mosi_arr[4];
  logic [7:0] miso_got[4];
  logic [7:0] rnd_tx[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: every o_rx_valid pops the expected queue; otherwise o_rx_byte must hold
  always @(negedge clk) begin
    if (!i_rst && mon_en) begin
      if (o_rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          check("rx_unexpected_pulse", 32'(o_rx_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_byte", 32'(o_rx_byte), 32'(mon_e));
          last_rx = mon_e;
        end
      end else begin
        check("rx_hold", 32'(o_rx_byte), 32'(last_rx));
      end
`ifdef SPI_PERIPH_ERR_EN
      if (o_tx_underrun) seen_underrun++;
      if (o_frame_err) seen_ferr++;
`endif
    end
  end

  task automatic clear_model();
    tx_q.delete();
    exp_q.delete();
    last_rx       = 8'h00;
    rx_cnt        = 0;
    exp_underrun  = 0;
    exp_ferr      = 0;
    seen_underrun = 0;
    seen_ferr     = 0;
  endtask

  task automatic check_reset_values();
    check("rst_poci", 32'(o_poci), 32'd0);
    check("rst_tx_ready", 32'(o_tx_ready), 32'd1);
    check("rst_rx_byte", 32'(o_rx_byte), 32'd0);
    check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
`ifdef SPI_PERIPH_ERR_EN
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_tx_underrun", 32'(o_tx_underrun), 32'd0);
`endif
  endtask

  task automatic check_err();
`ifdef SPI_PERIPH_ERR_EN
    check("underrun_cnt", 32'(seen_underrun), 32'(exp_underrun));
    check("frame_err_cnt", 32'(seen_ferr), 32'(exp_ferr));
`endif
  endtask

  // driver: buffer write, waits (bounded) for o_tx_ready
  task automatic write_tx(input logic [7:0] b);
    int n = 0;
    while (!o_tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!o_tx_ready) begin
      check("tx_ready_wait", 32'(o_tx_ready), 32'd1);
    end else begin
      i_tx_byte  = b;
      i_tx_valid = 1'b1;
      tx_q.push_back(b);
      @(negedge clk);
      i_tx_valid = 1'b0;
    end
  endtask

  // driver: mode-0 controller; CS is released together with the last SCLK fall
  task automatic spi_xfer(input int nbytes, input int half, input int abort_rises);
    logic [7:0] exp_tx;
    int rises = 0;
    bit stop = 0;
    i_pico = mosi_arr[0][7];
    i_cs = 1'b0;
    tick(half);
    check("busy_start", 32'(o_busy), 32'd1);
    for (int b = 0; b < nbytes && !stop; b++) begin
      if (tx_q.size() > 0) begin
        exp_tx = tx_q.pop_front();
      end else begin
        exp_tx = IDLE_BYTE;
        exp_underrun++;
      end
      for (int k = 7; k >= 0 && !stop; k--) begin
        miso_got[b][k] = o_poci;
        i_sclk = 1'b1;
        rises++;
        if (k == 0) exp_q.push_back(mosi_arr[b]);
        tick(half);
        if (rises == abort_rises || (b == nbytes - 1 && k == 0)) begin
          i_sclk = 1'b0;
          i_cs = 1'b1;
          stop = 1;
        end else begin
          i_sclk = 1'b0;
          if (k == 0) i_pico = mosi_arr[b + 1][7];
          else i_pico = mosi_arr[b][k - 1];
        end
        tick(half);
      end
      if (abort_rises == 0) check("poci_byte", 32'(miso_got[b]), 32'(exp_tx));
    end
    if (abort_rises > 0) exp_ferr++;
    tick(8);
    check("poci_idle", 32'(o_poci), 32'd0);
    check("busy_end", 32'(o_busy), 32'd0);
    check("rx_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_sclk = 1'b0;
    i_cs = 1'b1;
    i_pico = 1'b0;
    i_tx_byte = 8'h00;
    i_tx_valid = 1'b0;
    mon_en = 0;
    clear_model();
    tick(3);
    check_reset_values();
    i_rst = 1'b0;
    tick(4);
    mon_en = 1;

    // single byte
    write_tx(8'hA5);
    check("tx_ready_full", 32'(o_tx_ready), 32'd0);
    mosi_arr[0] = 8'h3C;
    rx_cnt = 0;
    spi_xfer(1, 6, 0);
    check("single_poci_lit", 32'(miso_got[0]), 32'hA5);
    check("single_rx_lit", 32'(o_rx_byte), 32'h3C);
    check("single_rx_pulses", 32'(rx_cnt), 32'd1);
    check("single_ready_after", 32'(o_tx_ready), 32'd1);
    check_err();

    // back-to-back
    write_tx(8'h12);
    mosi_arr[0] = 8'hF0;
    mosi_arr[1] = 8'h0F;
    rx_cnt = 0;
    fork
      spi_xfer(2, 6, 0);
      write_tx(8'h34);
    join
    check("b2b_poci0_lit", 32'(miso_got[0]), 32'h12);
    check("b2b_poci1_lit", 32'(miso_got[1]), 32'h34);
    check("b2b_rx_lit", 32'(o_rx_byte), 32'h0F);
    check("b2b_rx_pulses", 32'(rx_cnt), 32'd2);
    check_err();

    // underrun
    mosi_arr[0] = 8'h81;
    spi_xfer(1, 6, 0);
    check("underrun_poci_lit", 32'(miso_got[0]), 32'hFF);
    check_err();

    // abort after 5 rises, then a realigned frame
    mosi_arr[0] = 8'h77;
    rx_cnt = 0;
    spi_xfer(1, 6, 5);
    check("abort_no_rx", 32'(rx_cnt), 32'd0);
    check("abort_rx_keep_lit", 32'(o_rx_byte), 32'h81);
    check_err();
    write_tx(8'h69);
    mosi_arr[0] = 8'hC5;
    spi_xfer(1, 6, 0);
    check("realign_poci_lit", 32'(miso_got[0]), 32'h69);
    check("realign_rx_lit", 32'(o_rx_byte), 32'hC5);
    check_err();

    // reset mid-transfer
    write_tx(8'h5A);
    i_pico = 1'b1;
    i_cs = 1'b0;
    tick(6);
    repeat (3) begin
      i_sclk = 1'b1;
      tick(6);
      i_sclk = 1'b0;
      tick(6);
    end
    mon_en = 0;
    i_rst = 1'b1;
    i_cs = 1'b1;
    i_sclk = 1'b0;
    #1;
    check_reset_values();
    clear_model();
    tick(3);
    i_rst = 1'b0;
    tick(4);
    mon_en = 1;
    write_tx(8'hC3);
    mosi_arr[0] = 8'h96;
    rx_cnt = 0;
    spi_xfer(1, 6, 0);
    check("post_rst_poci_lit", 32'(miso_got[0]), 32'hC3);
    check("post_rst_rx_lit", 32'(o_rx_byte), 32'h96);
    check("post_rst_rx_pulses", 32'(rx_cnt), 32'd1);
    check_err();

    // ratio limit: SCLK = i_clk / 8
    for (int i = 0; i < 4; i++) begin
      mosi_arr[i] = 8'($urandom_range(0, 255));
      rnd_tx[i] = 8'($urandom_range(0, 255));
    end
    rx_cnt = 0;
    write_tx(rnd_tx[0]);
    fork
      spi_xfer(4, 4, 0);
      begin
        for (int i = 1; i < 4; i++) write_tx(rnd_tx[i]);
      end
    join
    for (int i = 0; i < 4; i++) check("ratio_poci", 32'(miso_got[i]), 32'(rnd_tx[i]));
    check("ratio_rx_pulses", 32'(rx_cnt), 32'd4);
    check("ratio_rx_last", 32'(o_rx_byte), 32'(mosi_arr[3]));
    check_err();

    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
